// File: rtl/tank_pkg.sv
// Shared types and constants for the tank game bullet pool: facing directions,
// tank geometry, screen limits and the per-slot bullet record.
package tank_pkg;

  typedef enum logic [2:0] {
    DIR_UP    = 3'd1,
    DIR_RIGHT = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_DOWN  = 3'd4
  } dir_t;

  localparam int unsigned TANK_SIZE    = 32;
  localparam int unsigned MUZZLE_OFS   = 16;
  localparam int unsigned SCREEN_X_MAX = 639;
  localparam int unsigned SCREEN_Y_MAX = 479;
  localparam int unsigned COORD_W      = 10;
  localparam int unsigned VEL_W        = 4;
  localparam int unsigned LIFE_W       = 8;

  typedef struct packed {
    logic                     active;
    logic                     owner;
    logic [COORD_W-1:0]       x;
    logic [COORD_W-1:0]       y;
    logic signed [VEL_W-1:0]  vx;
    logic signed [VEL_W-1:0]  vy;
    logic [LIFE_W-1:0]        life;
  } slot_t;

  function automatic logic dir_valid(input logic [2:0] dir);
    return (dir >= 3'd1) && (dir <= 3'd4);
  endfunction

  // Muzzle position and velocity for a tank at (tx, ty) facing dir.
  function automatic slot_t spawn_payload(input logic [COORD_W-1:0] tx,
                                          input logic [COORD_W-1:0] ty,
                                          input logic [2:0]         dir,
                                          input logic               owner,
                                          input int unsigned        step,
                                          input int unsigned        life);
    slot_t                   s;
    logic [COORD_W-1:0]      ofs;
    logic [COORD_W-1:0]      size;
    logic signed [VEL_W-1:0] v;
    ofs      = COORD_W'(MUZZLE_OFS);
    size     = COORD_W'(TANK_SIZE);
    v        = VEL_W'(step);
    s        = '0;
    s.active = 1'b1;
    s.owner  = owner;
    s.life   = LIFE_W'(life);
    case (dir)
      DIR_UP: begin
        s.x  = tx + ofs;
        s.y  = ty;
        s.vy = -v;
      end
      DIR_DOWN: begin
        s.x  = tx + ofs;
        s.y  = ty + size;
        s.vy = v;
      end
      DIR_LEFT: begin
        s.x  = tx;
        s.y  = ty + ofs;
        s.vx = -v;
      end
      DIR_RIGHT: begin
        s.x  = tx + size;
        s.y  = ty + ofs;
        s.vx = v;
      end
      default: s.active = 1'b0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: loads on spawn, advances once per frame tick, and retires on
// hit, lifetime expiry or leaving the screen.
module bullet_slot
  import tank_pkg::*;
#(
  parameter int unsigned X_MAX = SCREEN_X_MAX,
  parameter int unsigned Y_MAX = SCREEN_Y_MAX
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_tick,
  input  logic               spawn,
  input  slot_t              spawn_slot,
  input  logic               hit,
  output logic               active,
  output logic               owner,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);

  localparam int unsigned PosW = COORD_W + 2;
  localparam logic signed [PosW-1:0] XLim = PosW'(X_MAX);
  localparam logic signed [PosW-1:0] YLim = PosW'(Y_MAX);

  slot_t                  slot_q;
  logic signed [PosW-1:0] next_x;
  logic signed [PosW-1:0] next_y;
  logic                   retire;

  // Wider signed arithmetic so a step past either edge is seen, never wrapped.
  always_comb begin
    next_x = $signed({2'b00, slot_q.x}) +
             $signed({{(PosW-VEL_W){slot_q.vx[VEL_W-1]}}, slot_q.vx});
    next_y = $signed({2'b00, slot_q.y}) +
             $signed({{(PosW-VEL_W){slot_q.vy[VEL_W-1]}}, slot_q.vy});
    retire = (slot_q.life <= LIFE_W'(1)) || next_x[PosW-1] || next_y[PosW-1] ||
             (next_x > XLim) || (next_y > YLim);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      slot_q <= '0;
    end else if (slot_q.active) begin
      if (hit) begin
        slot_q.active <= 1'b0;
      end else if (frame_tick) begin
        if (retire) begin
          slot_q.active <= 1'b0;
        end else begin
          slot_q.x    <= next_x[COORD_W-1:0];
          slot_q.y    <= next_y[COORD_W-1:0];
          slot_q.life <= slot_q.life - LIFE_W'(1);
        end
      end
    end else if (spawn) begin
      slot_q <= spawn_slot;
    end
  end

  assign active = slot_q.active;
  assign owner  = slot_q.owner;
  assign x      = slot_q.x;
  assign y      = slot_q.y;

endmodule

// File: rtl/bullet_pool_arbiter.sv
// Shares a pool of bullet slots between two tanks: latches fire presses,
// applies per-player cooldown and hands out free slots once per frame.
module bullet_pool_arbiter
  import tank_pkg::*;
#(
  parameter int unsigned NUM_SLOTS       = 4,
  parameter int unsigned COOLDOWN_FRAMES = 30,
  parameter int unsigned LIFETIME_FRAMES = 120,
  parameter int unsigned STEP            = 2,
  parameter int unsigned X_MAX           = SCREEN_X_MAX,
  parameter int unsigned Y_MAX           = SCREEN_Y_MAX
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  input  logic [1:0]             fire_req,
  input  logic [2:0]             p0_dir,
  input  logic [2:0]             p1_dir,
  input  logic [9:0]             p0_x,
  input  logic [9:0]             p0_y,
  input  logic [9:0]             p1_x,
  input  logic [9:0]             p1_y,
  input  logic [NUM_SLOTS-1:0]   slot_hit,
  output logic [1:0]             fire_grant,
  output logic [NUM_SLOTS-1:0]   slot_active,
  output logic [NUM_SLOTS-1:0]   slot_owner,
  output logic [10*NUM_SLOTS-1:0] slot_x,
  output logic [10*NUM_SLOTS-1:0] slot_y,
  output logic                   pool_full
);

  localparam int unsigned IdxW = $clog2(NUM_SLOTS);
  localparam int unsigned CdW  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  logic [2:0]            frame_sync_q;
  logic                  frame_tick;
  logic [1:0]            fire_req_q;
  logic [1:0]            fire_rise;
  logic [1:0]            pending_q, pending_d;
  logic [1:0][CdW-1:0]   cooldown_q, cooldown_d;
  logic                  rr_q, rr_d;
  logic [1:0]            fire_grant_q, grant_d;
  logic [1:0]            dir_ok, want;
  logic [NUM_SLOTS-1:0]  active_vec, spawn_vec, spawn_owner;
  logic [IdxW-1:0]       first_idx, second_idx;
  logic [IdxW-1:0]       sel [2];
  logic                  have_first, have_second;
  slot_t                 payload [2];

  // Bits [1:0] synchronise frame_clk, bit [2] is the previous value for edge detect.
  assign frame_tick = frame_sync_q[1] & ~frame_sync_q[2];
  assign fire_rise  = fire_req & ~fire_req_q;

  assign payload[0] = spawn_payload(p0_x, p0_y, p0_dir, 1'b0, STEP, LIFETIME_FRAMES);
  assign payload[1] = spawn_payload(p1_x, p1_y, p1_dir, 1'b1, STEP, LIFETIME_FRAMES);

  always_comb begin
    first_idx   = '0;
    second_idx  = '0;
    have_first  = 1'b0;
    have_second = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!active_vec[i]) begin
        if (!have_first) begin
          first_idx  = IdxW'(i);
          have_first = 1'b1;
        end else if (!have_second) begin
          second_idx  = IdxW'(i);
          have_second = 1'b1;
        end
      end
    end
  end

  always_comb begin
    dir_ok  = {dir_valid(p1_dir), dir_valid(p0_dir)};
    want    = pending_q & dir_ok;
    grant_d = '0;
    sel[0]  = first_idx;
    sel[1]  = first_idx;
    rr_d    = rr_q;
    if (frame_tick) begin
      if (&want) begin
        if (have_second) begin
          grant_d = 2'b11;
          sel[1]  = second_idx;
        end else if (have_first) begin
          grant_d[rr_q] = 1'b1;
          rr_d          = ~rr_q;
        end
      end else if (have_first) begin
        grant_d = want;
      end
    end
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      spawn_owner[i] = grant_d[1] && (sel[1] == IdxW'(i));
      spawn_vec[i]   = (grant_d[0] && (sel[0] == IdxW'(i))) || spawn_owner[i];
    end
  end

  always_comb begin
    pending_d  = pending_q;
    cooldown_d = cooldown_q;
    for (int p = 0; p < 2; p++) begin
      if (frame_tick) begin
        // A pending shot with no valid facing is discarded, not deferred.
        if (grant_d[p] || !dir_ok[p]) pending_d[p] = 1'b0;
        if (grant_d[p]) begin
          cooldown_d[p] = CdW'(COOLDOWN_FRAMES);
        end else if (cooldown_q[p] != '0) begin
          cooldown_d[p] = cooldown_q[p] - CdW'(1);
        end
      end
      if (fire_rise[p] && (cooldown_q[p] == '0) && !grant_d[p]) pending_d[p] = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_sync_q <= '0;
      fire_req_q   <= '0;
      pending_q    <= '0;
      cooldown_q   <= '0;
      rr_q         <= 1'b0;
      fire_grant_q <= '0;
    end else begin
      frame_sync_q <= {frame_sync_q[1:0], frame_clk};
      fire_req_q   <= fire_req;
      pending_q    <= pending_d;
      cooldown_q   <= cooldown_d;
      rr_q         <= rr_d;
      fire_grant_q <= grant_d;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    bullet_slot #(
      .X_MAX(X_MAX),
      .Y_MAX(Y_MAX)
    ) u_slot (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .frame_tick (frame_tick),
      .spawn      (spawn_vec[i]),
      .spawn_slot (spawn_owner[i] ? payload[1] : payload[0]),
      .hit        (slot_hit[i]),
      .active     (active_vec[i]),
      .owner      (slot_owner[i]),
      .x          (slot_x[10*i +: 10]),
      .y          (slot_y[10*i +: 10])
    );
  end

  assign slot_active = active_vec;
  assign fire_grant  = fire_grant_q;
  assign pool_full   = &active_vec;

endmodule

// File: tb/tb_bullet_pool_arbiter.sv
// Directed bench for bullet_pool_arbiter: grant/spawn, cooldown, contention,
// off-screen retire, lifetime and asynchronous reset.
module tb_bullet_pool_arbiter;

  localparam int unsigned NumSlots = 4;

  logic                    Clk = 1'b0;
  logic                    Reset_n = 1'b0;
  logic                    frame_clk = 1'b0;
  logic [1:0]              fire_req;
  logic [2:0]              p0_dir, p1_dir;
  logic [9:0]              p0_x, p0_y, p1_x, p1_y;
  logic [NumSlots-1:0]     slot_hit;
  logic [1:0]              fire_grant;
  logic [NumSlots-1:0]     slot_active, slot_owner;
  logic [10*NumSlots-1:0]  slot_x, slot_y;
  logic                    pool_full;

  int         checks = 0;
  int         failures = 0;
  logic [1:0] grant_seen;
  int         grant_cycles;
  int         grant_events;

  bullet_pool_arbiter #(
    .NUM_SLOTS(NumSlots)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_clk   (frame_clk),
    .fire_req    (fire_req),
    .p0_dir      (p0_dir),
    .p1_dir      (p1_dir),
    .p0_x        (p0_x),
    .p0_y        (p0_y),
    .p1_x        (p1_x),
    .p1_y        (p1_y),
    .slot_hit    (slot_hit),
    .fire_grant  (fire_grant),
    .slot_active (slot_active),
    .slot_owner  (slot_owner),
    .slot_x      (slot_x),
    .slot_y      (slot_y),
    .pool_full   (pool_full)
  );

  always #10 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame_clk pulse; records any fire_grant seen during the resulting tick.
  task automatic frame();
    grant_seen   = '0;
    grant_cycles = 0;
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (4) begin
      @(negedge Clk);
      grant_seen = grant_seen | fire_grant;
      if (fire_grant != 2'b00) grant_cycles++;
    end
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    if (grant_seen != 2'b00) grant_events++;
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic press(input logic [1:0] keys);
    @(negedge Clk);
    fire_req = fire_req | keys;
    @(negedge Clk);
  endtask

  task automatic release_keys(input logic [1:0] keys);
    @(negedge Clk);
    fire_req = fire_req & ~keys;
    @(negedge Clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    fire_req = 2'b00;
    slot_hit = '0;
    p0_dir = 3'd2; p0_x = 10'd100; p0_y = 10'd200;
    p1_dir = 3'd1; p1_x = 10'd300; p1_y = 10'd300;
    grant_events = 0;
    repeat (3) @(negedge Clk);
    check_eq("rst_active", slot_active, 4'b0000);
    check_eq("rst_full", pool_full, 1'b0);
    check_eq("rst_grant", fire_grant, 2'b00);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Grant G: p0 right from (100,200)
    press(2'b01);
    frame();
    check_eq("t1_grant", grant_seen, 2'b01);
    check_eq("t1_pulse", grant_cycles, 1);
    check_eq("t1_active", slot_active, 4'b0001);
    check_eq("t1_owner", slot_owner, 4'b0000);
    check_eq("t1_x0", slot_x[9:0], 132);
    check_eq("t1_y0", slot_y[9:0], 216);
    frame();
    check_eq("t1_adv_x0", slot_x[9:0], 134);
    check_eq("t1_adv_y0", slot_y[9:0], 216);

    // Held key through frame 10, new edge at frame 20, edge after frame 30
    grant_events = 0;
    frames(9);
    check_eq("t2_held", grant_events, 0);
    release_keys(2'b01);
    frames(10);
    press(2'b01);
    release_keys(2'b01);
    frames(10);
    check_eq("t2_early_drop", grant_events, 0);
    press(2'b01);
    release_keys(2'b01);
    frame();
    check_eq("t2_regrant", grant_seen, 2'b01);
    check_eq("t2_active", slot_active, 4'b0011);
    check_eq("t2_x1", slot_x[19:10], 132);

    // G+32: p1 up from (300,300) into slot2
    press(2'b10);
    release_keys(2'b10);
    frame();
    check_eq("t3_p1_grant", grant_seen, 2'b10);
    check_eq("t3_active3", slot_active, 4'b0111);
    check_eq("t3_owner3", slot_owner, 4'b0100);
    check_eq("t3_x2", slot_x[29:20], 316);
    check_eq("t3_y2", slot_y[29:20], 300);
    frames(30);

    // G+63: contention for the last slot, rr favours p0
    press(2'b11);
    release_keys(2'b11);
    frame();
    check_eq("t3_contend_grant", grant_seen, 2'b01);
    check_eq("t3_contend_active", slot_active, 4'b1111);
    check_eq("t3_full", pool_full, 1'b1);
    @(negedge Clk);
    slot_hit = 4'b0010;
    @(negedge Clk);
    slot_hit = 4'b0000;
    check_eq("t3_hit_active", slot_active, 4'b1101);
    check_eq("t3_hit_full", pool_full, 1'b0);

    // G+64: deferred p1 shot lands in freed slot1, then reset mid-flight
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    check_eq("t3_p1_late", fire_grant, 2'b10);
    check_eq("t3_late_active", slot_active, 4'b1111);
    check_eq("t3_late_owner", slot_owner, 4'b0110);
    check_eq("t3_x0", slot_x[9:0], 260);
    check_eq("t3_y2", slot_y[29:20], 236);
    #1 Reset_n = 1'b0;
    #1;
    check_eq("t6_active", slot_active, 4'b0000);
    check_eq("t6_full", pool_full, 1'b0);
    check_eq("t6_grant", fire_grant, 2'b00);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Grant H after reset
    press(2'b01);
    release_keys(2'b01);
    frame();
    check_eq("t6_refire", grant_seen, 2'b01);
    check_eq("t6_re_active", slot_active, 4'b0001);
    check_eq("t6_re_x0", slot_x[9:0], 132);

    // H+1: spawn past the right edge
    p1_x = 10'd620; p1_y = 10'd100; p1_dir = 3'd2;
    press(2'b10);
    release_keys(2'b10);
    frame();
    check_eq("t4_r_grant", grant_seen, 2'b10);
    check_eq("t4_r_active", slot_active, 4'b0011);
    check_eq("t4_r_x1", slot_x[19:10], 652);
    frame();
    check_eq("t4_r_retire", slot_active, 4'b0001);
    check_eq("t4_r_stale", slot_x[19:10], 652);
    frames(29);

    // H+32: left-moving bullet at x=1
    p1_x = 10'd1; p1_y = 10'd50; p1_dir = 3'd3;
    press(2'b10);
    release_keys(2'b10);
    frame();
    check_eq("t4_l_active", slot_active, 4'b0011);
    check_eq("t4_l_x1", slot_x[19:10], 1);
    check_eq("t4_l_y1", slot_y[19:10], 66);
    frame();
    check_eq("t4_l_retire", slot_active, 4'b0001);
    check_eq("t4_l_nowrap", slot_x[19:10], 1);

    // H+34/35: invalid facing discards the request
    p0_dir = 3'd0;
    press(2'b01);
    release_keys(2'b01);
    frame();
    check_eq("bad_dir_grant", grant_seen, 2'b00);
    p0_dir = 3'd2;
    frame();
    check_eq("bad_dir_cleared", grant_seen, 2'b00);
    check_eq("bad_dir_active", slot_active, 4'b0001);

    // Lifetime: slot0 spawned at H retires at H+120
    frames(84);
    check_eq("t5_alive_119", slot_active, 4'b0001);
    check_eq("t5_x0_119", slot_x[9:0], 370);
    frame();
    check_eq("t5_dead_120", slot_active, 4'b0000);
    check_eq("t5_stale_x0", slot_x[9:0], 370);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
